// File: rtl/mem_arbiter.sv
// Purpose : lets the instruction-fetch port and the data port share one single-ported
//           32-bit memory. Data wins ties; after MAX_D_STREAK data grants in a row
//           with a fetch waiting, the fetch is forced through. A watchdog aborts
//           accesses the memory never acknowledges.
// Latency : request sampled in IDLE -> mem_req next cycle. mem_ack -> ready pulse next
//           cycle -> IDLE the cycle after. Best case is 2 cycles from request to ready.
// Backpres: a requester holds req until its one-cycle ready pulse (stall = req & ~ready).
//           mem_req is held until mem_ack or a watchdog abort.
// Ports   : clock/reset (sync, active-high); i_req/i_addr -> i_rdata/i_ready (fetch);
//           d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready (data); err pulses with a ready
//           when that access timed out; mem_req/mem_we/mem_addr/mem_wdata and
//           mem_rdata/mem_ack form the memory handshake.
module mem_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // The streak counter is at least 3 bits wide. The wait counter only has to reach
    // TIMEOUT-1, because the abort fires in the last permitted cycle of mem_req.
    localparam int SW = (MAX_D_STREAK < 8) ? 3 : $clog2(MAX_D_STREAK + 1);
    localparam int WW = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [WW-1:0] WAIT_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_I_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]    r_state;
    logic [SW-1:0] r_streak;
    logic [WW-1:0] r_wait;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;
    logic          r_i_ready;
    logic          r_d_ready;
    logic          r_err;

    logic w_grant_d;
    logic w_grant_i;
    logic w_is_i;
    logic w_timeout;

    // Data wins a tie unless it has already used up its streak while a fetch waited.
    assign w_grant_d = d_req && (!i_req || (r_streak != STREAK_MAX));
    assign w_grant_i = i_req && !w_grant_d;
    assign w_is_i    = (r_state == S_I_BUSY);
    // An ack in the final permitted cycle still completes the access normally.
    assign w_timeout = (TIMEOUT != 0) && !mem_ack && (r_wait == WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_wait      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Ready and err are pulses: they are high only for the RESP cycle.
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= S_D_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_wait      <= '0;
                        // A data grant made with a fetch waiting counts toward the
                        // streak. It cannot overflow, because a full streak forces
                        // the fetch grant instead.
                        if (i_req) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_state     <= S_I_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_mem_wdata <= '0;
                        r_wait      <= '0;
                        r_streak    <= '0;
                    end
                end
                S_I_BUSY, S_D_BUSY: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                        r_i_ready <= w_is_i;
                        r_d_ready <= !w_is_i;
                        if (w_is_i) begin
                            r_i_rdata <= mem_rdata;
                        end else if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                        r_i_ready <= w_is_i;
                        r_d_ready <= !w_is_i;
                        r_err     <= 1'b1;
                        if (w_is_i) begin
                            r_i_rdata <= '0;
                        end else begin
                            r_d_rdata <= '0;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = r_i_rdata;
    assign i_ready   = r_i_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed bench for mem_arbiter with a behavioural memory and a
//           scoreboard of expected ready responses (port, rdata, err).
// Latency : inputs change 1 time unit after the rising edge, the memory model
//           responds 2 units after it, and the monitor samples on the falling edge.
// Backpres: requesters hold req until their ready pulse.
module tb_mem_arbiter;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] mem_model[logic [31:0]];

    int   ack_delay  = 1;   // ack arrives in this mem_req cycle; 0 = never
    logic inject_ack = 1'b0;
    int   req_cycles = 0;
    logic we_all     = 1'b1;

    mem_arbiter #(.TIMEOUT(16), .MAX_D_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [31:0] rdata, input logic e);
        exp_t x;
        x.is_d  = is_d;
        x.rdata = rdata;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Waits for either ready pulse, counting rising edges from the call.
    task automatic wait_ready(input int budget, output int lat);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!(i_ready || d_ready) && lat < budget);
        if (!(i_ready || d_ready)) chk("ready_timeout", {31'b0, i_ready | d_ready}, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    // Memory model: acks in mem_req cycle number ack_delay of each access.
    initial begin
        logic prev_req;
        prev_req  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_model[32'h0000_0040] = 32'h2008_0005;
        mem_model[32'h0000_0020] = 32'h1234_5678;
        forever begin
            @(posedge clock); #2;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req && !prev_req) begin
                req_cycles = 0;
                we_all     = 1'b1;
                grant_log.push_back(mem_addr);
            end
            if (mem_req) begin
                req_cycles++;
                we_all = we_all & mem_we;
                if (ack_delay != 0 && req_cycles == ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else        mem_rdata = rd(mem_addr);
                end
            end
            if (inject_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            prev_req = mem_req;
        end
    end

    // Scoreboard monitor: every ready pulse pops and compares one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                if (i_ready || d_ready) begin
                    chk("both_ready", {31'b0, i_ready & d_ready}, 32'd0);
                    chk("mem_req_in_resp", {31'b0, mem_req}, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", {30'b0, i_ready, d_ready}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ready_port_d", {31'b0, d_ready}, {31'b0, e.is_d});
                        chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                        chk("err", {31'b0, err}, {31'b0, e.err});
                    end
                end else if (err) begin
                    chk("err_without_ready", {31'b0, err}, 32'd0);
                end
            end
        end
    end

    initial begin
        int lat;
        logic [31:0] order[10];
        reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        step(3);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ready", {30'b0, i_ready, d_ready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);
        reset = 1'b0;
        step(2);

        // Single fetch, ack in the first mem_req cycle.
        ack_delay = 1;
        i_addr = 32'h0000_0040; i_req = 1'b1;
        push_exp(1'b0, 32'h2008_0005, 1'b0);
        wait_ready(10, lat);
        i_req = 1'b0;
        chk("fetch_latency", lat, 32'd2);
        chk("fetch_req_cycles", req_cycles, 32'd1);
        chk("fetch_mem_addr", grant_log[$], 32'h0000_0040);
        step(2);

        // Load to give d_rdata a known value, then a store that must not disturb it.
        d_we = 1'b0; d_addr = 32'h20; d_req = 1'b1;
        push_exp(1'b1, 32'h1234_5678, 1'b0);
        wait_ready(10, lat);
        d_req = 1'b0;
        step(1);
        ack_delay = 3;
        d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
        push_exp(1'b1, 32'h1234_5678, 1'b0);
        wait_ready(10, lat);
        d_req = 1'b0;
        chk("store_latency", lat, 32'd4);
        chk("store_req_cycles", req_cycles, 32'd3);
        chk("store_we_held", {31'b0, we_all}, 32'd1);
        chk("store_written", rd(32'h10), 32'hCAFE_F00D);
        step(1);
        ack_delay = 2;
        d_we = 1'b0; d_req = 1'b1;
        push_exp(1'b1, 32'hCAFE_F00D, 1'b0);
        wait_ready(10, lat);
        d_req = 1'b0;
        chk("load_latency", lat, 32'd3);
        step(2);

        // Contention: both held high, expect D,D,D,D,I,D,D,D,D,I.
        ack_delay = 1;
        grant_log.delete();
        for (int k = 0; k < 10; k++) begin
            order[k] = (k == 4 || k == 9) ? 32'h100 : 32'h200;
            push_exp(order[k] == 32'h200, rd(order[k]), 1'b0);
        end
        i_addr = 32'h100; i_req = 1'b1;
        d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
        for (int k = 0; k < 10; k++) wait_ready(10, lat);
        i_req = 1'b0; d_req = 1'b0;
        step(3);
        chk("contention_grants", grant_log.size(), 32'd10);
        for (int k = 0; k < 10 && k < grant_log.size(); k++)
            chk($sformatf("grant_%0d", k), grant_log[k], order[k]);

        // Timeout: no ack ever, then stray acks that must be ignored.
        ack_delay = 0;
        d_addr = 32'h30; d_we = 1'b0; d_req = 1'b1;
        push_exp(1'b1, 32'd0, 1'b1);
        wait_ready(40, lat);
        d_req = 1'b0;
        chk("timeout_latency", lat, 32'd17);
        chk("timeout_req_cycles", req_cycles, 32'd16);
        inject_ack = 1'b1;
        step(2);
        inject_ack = 1'b0;
        step(3);
        chk("late_ack_mem_req", {31'b0, mem_req}, 32'd0);
        chk("late_ack_rdata", d_rdata, 32'd0);

        // Reset in the middle of a data access that is still waiting for its ack.
        d_addr = 32'h44; d_req = 1'b1;
        step(3);
        chk("pre_reset_busy", {31'b0, mem_req}, 32'd1);
        reset = 1'b1; d_req = 1'b0;
        step(1);
        chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_i_rdata", i_rdata, 32'd0);
        chk("mid_rst_ready", {29'b0, i_ready, d_ready, err}, 32'd0);
        reset = 1'b0;
        step(4);
        ack_delay = 2;
        i_addr = 32'h40; i_req = 1'b1;
        push_exp(1'b0, 32'h2008_0005, 1'b0);
        wait_ready(10, lat);
        i_req = 1'b0;
        chk("post_reset_latency", lat, 32'd3);
        step(3);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified 32-bit memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. Each requester holds a request until it gets a one-cycle ready pulse; the block drives the memory through a req/ack handshake. Grants favour data accesses, with a bounded-streak fairness rule and a watchdog timeout. Requesters' ready signals double as the IF and MEM stall conditions (stall = req & ~ready).

## Interface
- TIMEOUT, 16: max cycles waiting for mem_ack before abort; 0 disables the watchdog.
- MAX_D_STREAK, 4: consecutive data grants allowed while i_req is pending before instruction is forced.

- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  instruction fetch request, held until i_ready.
- i_addr  in  32  fetch byte address, stable while i_req.
- i_rdata  out  32  fetched word, valid when i_ready.
- i_ready  out  1  one-cycle completion pulse, fetch port.
- d_req  in  1  data request, held until d_ready.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, valid when d_ready on a load.
- d_ready  out  1  one-cycle completion pulse, data port.
- err  out  1  pulses with i_ready/d_ready when the access timed out.
- mem_req  out  1  memory request, held until mem_ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid in mem_ack cycle.
- mem_ack  in  1  one-cycle acknowledge from memory.

## Operation
- All outputs registered. States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: arbitrate sampled requests. Only i_req -> I_BUSY. Only d_req -> D_BUSY. Both: D_BUSY unless d_streak == MAX_D_STREAK, then I_BUSY. Neither: stay.
- On grant, latch requester's addr/we/wdata onto mem_addr/mem_we/mem_wdata and set mem_req = 1; instruction grants always mem_we = 0, mem_wdata = 0.
- d_streak (3+ bits): +1 on a data grant made while i_req = 1; cleared on any instruction grant; saturates at MAX_D_STREAK; unchanged on data grants with i_req = 0.
- I_BUSY/D_BUSY: hold mem_* stable. On mem_ack: mem_req -> 0, capture mem_rdata into i_rdata (I) or d_rdata (D, loads only; stores leave d_rdata unchanged), go RESP.
- Watchdog: wait counter cleared on grant, +1 each BUSY cycle without ack. When it reaches TIMEOUT (nonzero): mem_req -> 0, rdata register of the granted port <- 0, err armed, go RESP. mem_ack arriving in IDLE/RESP is ignored.
- RESP: pulse the granted port's ready (and err if armed) for exactly one cycle, then IDLE unconditionally.
- Requester may change addr/req the cycle after its ready; a req still high in IDLE is treated as a new access.
- Reset: state IDLE, mem_req/mem_we/i_ready/d_ready/err = 0, mem_addr/mem_wdata/i_rdata/d_rdata = 0, d_streak = 0, wait counter = 0. Reset mid-access abandons it silently; no ready is issued.

## Timing
- Request sampled in IDLE at edge t -> mem_req high from t+1.
- mem_ack in cycle k -> ready (and rdata) high in cycle k+1 -> IDLE at k+2 -> next grant visible k+3.
- Minimum latency req-to-ready: 2 cycles (ack in first mem_req cycle); minimum spacing between grants: 3 cycles.
- Timeout: with no ack, mem_req high for exactly TIMEOUT cycles, ready+err in the next cycle.
- i_ready and d_ready never high in the same cycle; mem_req never high in RESP or IDLE.

## Test plan
- Single fetch: i_req, i_addr=0x0000_0040, memory acks first cycle with 0x2008_0005 -> mem_req 1 cycle, i_ready pulse 2 cycles after request, i_rdata = 0x2008_0005.
- Store then load: d_we=1, d_addr=0x10, d_wdata=0xCAFE_F00D, ack after 3 cycles -> mem_we=1 throughout, d_ready once, d_rdata unchanged; then load 0x10 -> d_rdata = 0xCAFE_F00D.
- Contention, MAX_D_STREAK=4: i_req and d_req held high continuously -> grant order D,D,D,D,I,D,D,D,D,I.
- Timeout, TIMEOUT=16: d_req load, mem_ack never asserted -> mem_req high 16 cycles, then d_ready=1, err=1, d_rdata=0; late mem_ack ignored.
- Reset mid-access: assert reset during D_BUSY with ack pending -> next cycle all outputs zero, no d_ready; fresh i_req after reset serviced normally.
